// File: rtl/cr_xp10_decomp_htf_bct_sat_seq.sv
// rtl/cr_xp10_decomp_htf_bct_sat_seq.sv - sequential per-length BCT/SAT writer for multiple Huffman tables
// Takes a code-length histogram and streams first-code/symbol-base beats with tree validity flags.
module cr_xp10_decomp_htf_bct_sat_seq #(
    parameter int MAX_DEPTH        = 27,
    parameter int WIDTH            = 10,
    parameter int NUM_TBL          = 2,
    parameter int TBL_W            = 1,
    parameter int ALLOW_INCOMPLETE = 0,
    parameter int ALLOW_SINGLE     = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               hist_valid,
    output logic                               hist_ready,
    input  logic [TBL_W-1:0]                   hist_tbl,
    input  logic [$clog2(MAX_DEPTH+1)-1:0]     hist_depth,
    input  logic [MAX_DEPTH*WIDTH-1:0]         histogram,
    input  logic                               flush,
    output logic                               wr_valid,
    input  logic                               wr_ready,
    output logic [TBL_W-1:0]                   wr_tbl,
    output logic [$clog2(MAX_DEPTH+1)-1:0]     wr_addr,
    output logic                               wr_last,
    output logic [1:0]                         wr_err,
    output logic                               bct_valid,
    output logic [MAX_DEPTH-1:0]               bct_data,
    output logic [WIDTH-1:0]                   sat_data
);

    localparam int DW    = $clog2(MAX_DEPTH + 1);
    localparam int ACC_W = MAX_DEPTH + 2;
    localparam int TOT_W = WIDTH + DW;

    typedef enum logic [1:0] {IDLE, WRITE, ERR} state_t;

    state_t                     state_q, state_d;
    logic [MAX_DEPTH*WIDTH-1:0] hist_q, hist_d;
    logic [TBL_W-1:0]           tbl_q, tbl_d;
    logic [DW-1:0]              depth_q, depth_d;
    logic [DW-1:0]              len_q, len_d;
    logic [ACC_W-1:0]           code_q, code_d;
    logic [WIDTH-1:0]           sat_q, sat_d;
    logic                       single_q, single_d;

    logic [WIDTH-1:0] cnt_l;
    logic [TOT_W-1:0] total;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] pow;
    logic             oversub;
    logic             incomplete;
    logic             last_len;
    logic             bad_hist;

    always_comb begin
        cnt_l = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (int'(len_q) == i + 1) cnt_l = hist_q[i*WIDTH +: WIDTH];
        end
    end

    // Total symbol count over the lengths actually in use; only "exactly one" matters.
    always_comb begin
        total = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (i < int'(hist_depth)) total = total + TOT_W'(histogram[i*WIDTH +: WIDTH]);
        end
    end

    // An out-of-range table id is reported like a bad depth rather than written anywhere.
    assign bad_hist = (hist_depth == '0) || (hist_depth > DW'(MAX_DEPTH)) ||
                      ({1'b0, hist_tbl} >= (TBL_W+1)'(NUM_TBL));

    assign sum        = code_q + ACC_W'(cnt_l);
    assign pow        = ACC_W'(1) << len_q;
    assign oversub    = (cnt_l != '0) && (sum > pow);
    assign last_len   = (len_q == depth_q);
    assign incomplete = (ALLOW_INCOMPLETE == 0) && (sum != pow) &&
                        !((ALLOW_SINGLE != 0) && single_q);

    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        tbl_d      = tbl_q;
        depth_d    = depth_q;
        len_d      = len_q;
        code_d     = code_q;
        sat_d      = sat_q;
        single_d   = single_q;
        hist_ready = 1'b0;
        wr_valid   = 1'b0;
        wr_tbl     = '0;
        wr_addr    = '0;
        wr_last    = 1'b0;
        wr_err     = 2'd0;
        bct_valid  = 1'b0;
        bct_data   = '0;
        sat_data   = '0;

        case (state_q)
            IDLE: begin
                hist_ready = 1'b1;
                if (hist_valid && !flush) begin
                    hist_d   = histogram;
                    tbl_d    = hist_tbl;
                    depth_d  = hist_depth;
                    len_d    = DW'(1);
                    code_d   = '0;
                    sat_d    = '0;
                    single_d = (total == TOT_W'(1));
                    state_d  = bad_hist ? ERR : WRITE;
                end
            end
            WRITE: begin
                wr_valid  = 1'b1;
                wr_tbl    = tbl_q;
                wr_addr   = len_q;
                bct_valid = (cnt_l != '0);
                bct_data  = code_q[MAX_DEPTH-1:0];
                sat_data  = sat_q;
                if (oversub) begin
                    wr_err  = 2'd1;
                    wr_last = 1'b1;
                end else if (last_len) begin
                    wr_last = 1'b1;
                    if (incomplete) wr_err = 2'd2;
                end
                if (wr_ready) begin
                    if (wr_last) begin
                        state_d = IDLE;
                    end else begin
                        code_d = sum << 1;
                        sat_d  = sat_q + cnt_l;
                        len_d  = len_q + DW'(1);
                    end
                end
            end
            ERR: begin
                wr_valid = 1'b1;
                wr_tbl   = tbl_q;
                wr_last  = 1'b1;
                wr_err   = 2'd3;
                if (wr_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hist_q   <= '0;
            tbl_q    <= '0;
            depth_q  <= '0;
            len_q    <= '0;
            code_q   <= '0;
            sat_q    <= '0;
            single_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            tbl_q    <= tbl_d;
            depth_q  <= depth_d;
            len_q    <= len_d;
            code_q   <= code_d;
            sat_q    <= sat_d;
            single_q <= single_d;
        end
    end

endmodule

// File: tb/tb_cr_xp10_decomp_htf_bct_sat_seq.sv
// tb/tb_cr_xp10_decomp_htf_bct_sat_seq.sv - directed table-driven bench for the BCT/SAT writer
module tb_cr_xp10_decomp_htf_bct_sat_seq;

    localparam int MD = 27;
    localparam int W  = 10;
    localparam int TW = 1;
    localparam int DW = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             hist_valid = 1'b0;
    logic             flush = 1'b0;
    logic             wr_ready = 1'b0;
    logic [TW-1:0]    hist_tbl = '0;
    logic [DW-1:0]    hist_depth = '0;
    logic [MD*W-1:0]  histogram = '0;

    logic             hist_ready, wr_valid, wr_last, bct_valid;
    logic [TW-1:0]    wr_tbl;
    logic [DW-1:0]    wr_addr;
    logic [1:0]       wr_err;
    logic [MD-1:0]    bct_data;
    logic [W-1:0]     sat_data;

    logic             hist_ready_i, wr_valid_i, wr_last_i, bct_valid_i;
    logic [TW-1:0]    wr_tbl_i;
    logic [DW-1:0]    wr_addr_i;
    logic [1:0]       wr_err_i;
    logic [MD-1:0]    bct_data_i;
    logic [W-1:0]     sat_data_i;

    logic             hist_ready_s, wr_valid_s, wr_last_s, bct_valid_s;
    logic [TW-1:0]    wr_tbl_s;
    logic [DW-1:0]    wr_addr_s;
    logic [1:0]       wr_err_s;
    logic [MD-1:0]    bct_data_s;
    logic [W-1:0]     sat_data_s;

    cr_xp10_decomp_htf_bct_sat_seq dut (
        .clk(clk), .rst_n(rst_n), .hist_valid(hist_valid), .hist_ready(hist_ready),
        .hist_tbl(hist_tbl), .hist_depth(hist_depth), .histogram(histogram), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_tbl(wr_tbl), .wr_addr(wr_addr),
        .wr_last(wr_last), .wr_err(wr_err), .bct_valid(bct_valid), .bct_data(bct_data),
        .sat_data(sat_data)
    );

    cr_xp10_decomp_htf_bct_sat_seq #(.ALLOW_INCOMPLETE(1)) dut_inc (
        .clk(clk), .rst_n(rst_n), .hist_valid(hist_valid), .hist_ready(hist_ready_i),
        .hist_tbl(hist_tbl), .hist_depth(hist_depth), .histogram(histogram), .flush(flush),
        .wr_valid(wr_valid_i), .wr_ready(wr_ready), .wr_tbl(wr_tbl_i), .wr_addr(wr_addr_i),
        .wr_last(wr_last_i), .wr_err(wr_err_i), .bct_valid(bct_valid_i), .bct_data(bct_data_i),
        .sat_data(sat_data_i)
    );

    cr_xp10_decomp_htf_bct_sat_seq #(.ALLOW_SINGLE(0)) dut_sgl (
        .clk(clk), .rst_n(rst_n), .hist_valid(hist_valid), .hist_ready(hist_ready_s),
        .hist_tbl(hist_tbl), .hist_depth(hist_depth), .histogram(histogram), .flush(flush),
        .wr_valid(wr_valid_s), .wr_ready(wr_ready), .wr_tbl(wr_tbl_s), .wr_addr(wr_addr_s),
        .wr_last(wr_last_s), .wr_err(wr_err_s), .bct_valid(bct_valid_s), .bct_data(bct_data_s),
        .sat_data(sat_data_s)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             tbl;
        logic [4:0]       depth;
        logic [2:0][9:0]  cnt;
        logic [1:0]       nb;
        logic [2:0][4:0]  addr;
        logic [2:0][26:0] bct;
        logic [2:0][9:0]  sat;
        logic [2:0]       bv;
        logic [1:0]       err;
        logic [1:0]       err_inc;
        logic [1:0]       err_sgl;
    } vec_t;

    vec_t vecs[8];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input int tbl, input int depth, input int c1, input int c2,
                                input int c3, input int nb, input int err, input int ei,
                                input int es);
        vec_t v;
        v         = '0;
        v.tbl     = tbl[0];
        v.depth   = depth[4:0];
        v.cnt[0]  = c1[9:0];
        v.cnt[1]  = c2[9:0];
        v.cnt[2]  = c3[9:0];
        v.nb      = nb[1:0];
        v.err     = err[1:0];
        v.err_inc = ei[1:0];
        v.err_sgl = es[1:0];
        return v;
    endfunction

    function automatic vec_t bt(input vec_t vi, input int i, input int addr, input int bct,
                                input int sat, input int bv);
        vec_t v;
        v         = vi;
        v.addr[i] = addr[4:0];
        v.bct[i]  = bct[26:0];
        v.sat[i]  = sat[9:0];
        v.bv[i]   = bv[0];
        return v;
    endfunction

    task automatic offer(input vec_t v, input string tag);
        chk({tag, ".hist_ready_idle"}, hist_ready, 1);
        histogram       = '0;
        histogram[0+:W] = v.cnt[0];
        histogram[W+:W] = v.cnt[1];
        histogram[2*W+:W] = v.cnt[2];
        hist_tbl   = v.tbl;
        hist_depth = v.depth;
        hist_valid = 1'b1;
        @(posedge clk);
        #1;
        hist_valid = 1'b0;
        chk({tag, ".first_valid"}, wr_valid, 1);
        chk({tag, ".hist_ready_busy"}, hist_ready, 0);
    endtask

    task automatic run_case(input vec_t v, input logic [7:0] pat, input string tag);
        int  beat = 0;
        bit  done = 0;
        logic last_e;
        logic [1:0] err_e, ei_e, es_e;
        offer(v, tag);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            wr_ready = (cyc < 8) ? pat[cyc] : 1'b1;
            #1;
            if (wr_valid) begin
                if (beat >= int'(v.nb)) begin
                    chk($sformatf("%s.extra_beat", tag), 1, 0);
                end else begin
                    last_e = (beat == int'(v.nb) - 1);
                    err_e  = last_e ? v.err : 2'd0;
                    ei_e   = last_e ? v.err_inc : 2'd0;
                    es_e   = last_e ? v.err_sgl : 2'd0;
                    chk($sformatf("%s.b%0d.tbl", tag, beat), wr_tbl, v.tbl);
                    chk($sformatf("%s.b%0d.addr", tag, beat), wr_addr, v.addr[beat]);
                    chk($sformatf("%s.b%0d.bct", tag, beat), bct_data, v.bct[beat]);
                    chk($sformatf("%s.b%0d.sat", tag, beat), sat_data, v.sat[beat]);
                    chk($sformatf("%s.b%0d.bv", tag, beat), bct_valid, v.bv[beat]);
                    chk($sformatf("%s.b%0d.last", tag, beat), wr_last, last_e);
                    chk($sformatf("%s.b%0d.err", tag, beat), wr_err, err_e);
                    chk($sformatf("%s.b%0d.err_inc", tag, beat), wr_err_i, ei_e);
                    chk($sformatf("%s.b%0d.err_sgl", tag, beat), wr_err_s, es_e);
                end
                if (wr_ready) begin
                    beat++;
                    if (wr_last) done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        chk({tag, ".completed"}, done, 1);
        chk({tag, ".beat_count"}, beat, v.nb);
        chk({tag, ".idle_valid"}, wr_valid, 0);
        chk({tag, ".idle_ready"}, hist_ready, 1);
    endtask

    initial begin
        int fb_bct[5];
        int fb_sat[5];
        vec_t fv;
        fb_bct = '{0, 0, 0, 2, 4};
        fb_sat = '{0, 0, 0, 1, 1};

        vecs[0] = mk(1, 3, 1, 1, 2, 3, 0, 0, 0);
        vecs[0] = bt(vecs[0], 0, 1, 0, 0, 1);
        vecs[0] = bt(vecs[0], 1, 2, 2, 1, 1);
        vecs[0] = bt(vecs[0], 2, 3, 6, 2, 1);
        vecs[1] = mk(0, 2, 3, 0, 0, 1, 1, 1, 1);
        vecs[1] = bt(vecs[1], 0, 1, 0, 0, 1);
        vecs[2] = mk(0, 3, 1, 1, 1, 3, 2, 0, 2);
        vecs[2] = bt(vecs[2], 0, 1, 0, 0, 1);
        vecs[2] = bt(vecs[2], 1, 2, 2, 1, 1);
        vecs[2] = bt(vecs[2], 2, 3, 6, 2, 1);
        vecs[3] = mk(1, 1, 1, 0, 0, 1, 0, 0, 2);
        vecs[3] = bt(vecs[3], 0, 1, 0, 0, 1);
        vecs[4] = mk(0, 0, 0, 0, 0, 1, 3, 3, 3);
        vecs[4] = bt(vecs[4], 0, 0, 0, 0, 0);
        vecs[5] = mk(1, 28, 1, 1, 2, 1, 3, 3, 3);
        vecs[5] = bt(vecs[5], 0, 0, 0, 0, 0);
        vecs[6] = mk(0, 3, 0, 3, 2, 3, 0, 0, 0);
        vecs[6] = bt(vecs[6], 0, 1, 0, 0, 0);
        vecs[6] = bt(vecs[6], 1, 2, 0, 0, 1);
        vecs[6] = bt(vecs[6], 2, 3, 6, 3, 1);
        vecs[7] = mk(1, 3, 1, 1, 3, 3, 1, 1, 1);
        vecs[7] = bt(vecs[7], 0, 1, 0, 0, 1);
        vecs[7] = bt(vecs[7], 1, 2, 2, 1, 1);
        vecs[7] = bt(vecs[7], 2, 3, 6, 2, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset.hist_ready", hist_ready, 1);
        chk("reset.wr_valid", wr_valid, 0);
        chk("reset.wr_last", wr_last, 0);
        chk("reset.wr_err", wr_err, 0);
        chk("reset.wr_addr", wr_addr, 0);
        chk("reset.bct_data", bct_data, 0);
        chk("reset.sat_data", sat_data, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_case(vecs[i], 8'hFF, $sformatf("vec%0d", i));

        run_case(vecs[0], 8'b1110_1001, "backpressure");

        // Deep stream aborted by flush on the 5th beat.
        fv = mk(0, 27, 0, 0, 1, 0, 0, 0, 0);
        offer(fv, "flush");
        for (int k = 0; k < 5; k++) begin
            wr_ready = 1'b1;
            flush = (k == 4);
            #1;
            chk($sformatf("flush.b%0d.valid", k), wr_valid, 1);
            chk($sformatf("flush.b%0d.addr", k), wr_addr, k + 1);
            chk($sformatf("flush.b%0d.bct", k), bct_data, fb_bct[k]);
            chk($sformatf("flush.b%0d.sat", k), sat_data, fb_sat[k]);
            chk($sformatf("flush.b%0d.last", k), wr_last, 0);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        chk("flush.after_valid", wr_valid, 0);
        chk("flush.after_last", wr_last, 0);
        chk("flush.after_ready", hist_ready, 1);
        run_case(vecs[0], 8'hFF, "post_flush");

        // Flush beats a simultaneous histogram offer in IDLE.
        histogram  = '0;
        histogram[0+:W] = 10'd2;
        hist_depth = 5'd1;
        hist_valid = 1'b1;
        flush      = 1'b1;
        @(posedge clk);
        #1;
        hist_valid = 1'b0;
        flush      = 1'b0;
        chk("idle_flush.valid", wr_valid, 0);
        chk("idle_flush.ready", hist_ready, 1);
        @(posedge clk);
        #1;
        chk("idle_flush.valid2", wr_valid, 0);

        // Asynchronous reset in the middle of a table.
        offer(vecs[0], "midreset");
        wr_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset.valid", wr_valid, 0);
        chk("midreset.ready", hist_ready, 1);
        chk("midreset.addr", wr_addr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_case(vecs[0], 8'hFF, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
